sequential_read_main: RTL and testbench
=======================================

Name: sequential_read_main

Overview:
Microbenchmark user-logic core, the read-side counterpart of the sequential-write benchmark. The control thread fills a CoramMemory1P with a known pattern, then sends a word count over a CoramChannel. The core reads that many words sequentially at one address per cycle, accumulates a checksum and, optionally, checks the pattern. It then returns cycle count, sum and error count to the control thread over the same channel.

Parameters:
SIMD_WIDTH, 4, lanes per memory word
LOG_SIMD_WIDTH, 2, log2(SIMD_WIDTH)
W_D, 32, bits per lane
W_A, 12, memory address width (depth 2^W_A words)
W_COMM_D, 32, channel data width
W_COMM_A, 4, channel FIFO address width

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
BUSY  output  1  high from count latch until last report word enqueued
DONE  output  1  one-cycle pulse when third report word is enqueued
SUM  output  32  running lane-sum accumulator (mod 2^32)
ERR_CNT  output  32  saturating mismatch counter

Behaviour:
- Internal instances: CoramMemory1P (thread "cthread_sequential_read", ID 0, SUB_ID 0, ADDR_LEN W_A, DATA_WIDTH W_D*SIMD_WIDTH). CoramChannel (same thread, ID 0, W_COMM_A/W_COMM_D). Memory WE and D are tied to 0; this core never writes.
- Memory read latency: Q is valid 1 cycle after ADDR is presented. Channel read latency: Q is valid 1 cycle after DEQ is asserted.
- Reset: state IDLE; BUSY=0, DONE=0, SUM=0, ERR_CNT=0; comm_enq=0, comm_deq=0, comm_d=0; mem_addr=0; cyclecount=0.
- comm_enq, comm_deq and DONE are single-cycle pulses, default 0 each cycle.
- IDLE: if !comm_empty, assert comm_deq and go to LATCH.
- LATCH: N = comm_q. Clamp N to 2^W_A if it is larger. Clear SUM, ERR_CNT, cyclecount and mem_addr. Set BUSY=1. If N==0, go to REP0; otherwise go to READ.
- READ: present mem_addr each cycle and increment it. Track the issued count. After issuing N addresses, go to DRAIN. The address wraps naturally at 2^W_A; the clamp guarantees no reuse.
- Valid pipeline: a 1-bit rd_valid, delayed 1 cycle from each issue. When rd_valid is high, SUM += sum over all SIMD_WIDTH lanes of mem_q, each lane W_D bits, truncated to 32 bits.
- DRAIN: wait 1 cycle for the final rd_valid, then go to REP0.
- cyclecount: increments every cycle while in READ or DRAIN. It is 0 otherwise after LATCH clears it.
- REP0: when !comm_full, enqueue cyclecount[31:0] and go to REP1.
- REP1: when !comm_full, enqueue SUM and go to REP2.
- REP2: when !comm_full, enqueue ERR_CNT, pulse DONE, clear BUSY and go to IDLE.
- Full channel: the REP state holds. comm_d and the counters stay stable.
- Channel words received outside IDLE are left in the FIFO. They are not dequeued until IDLE.
- RST mid-operation: immediate return to reset values. A partially read run is discarded and no report is sent.
- Simultaneous final rd_valid and state change: the last accumulate completes in DRAIN before REP0 samples SUM.

Optional Feature:
SEQUENTIAL_READ_CHECK_EN
- Defined: each valid lane value is compared against (word_index*SIMD_WIDTH + lane) mod 2^W_D, where word_index is the delayed read address. Each mismatching lane increments ERR_CNT, saturating at 0xFFFFFFFF.
- Undefined: no comparator logic is generated. ERR_CNT stays 0 and REP2 still enqueues 0, so the report length is always 3 words.

Test Plan:
- Memory preloaded with pattern i at lane index i; send N=16, SIMD_WIDTH=4 -> report {cyclecount=17, SUM=2016 (0..63), ERR_CNT=0}; DONE pulses once.
- N=0 -> no memory reads; report {0, 0, 0}; BUSY high for exactly 4 cycles (LATCH through REP2).
- Pattern with word 5 lane 2 corrupted to 0xDEAD, CHECK_EN defined, N=8 -> ERR_CNT=1 and SUM shifted by the delta. With CHECK_EN undefined -> ERR_CNT=0.
- N=5000 with W_A=12 -> clamped to 4096 reads; cyclecount=4097; no address repeat.
- comm_full held high for 10 cycles during REP1 -> core stalls; SUM word enqueued exactly once after release; report order preserved.
- RST asserted in mid-READ at N=100 -> outputs return to reset values, nothing enqueued; a following N=4 run reports correctly.

Source files
------------

// File: rtl/sequential_read_main.sv
// sequential_read_main: read-side memory-bandwidth microbenchmark core.
// Latency: one memory word per cycle; report is 3 channel words after a 1-cycle drain.
// Backpressure: report states hold while the channel reports full; new counts wait in the FIFO until IDLE.
//
// Ports (sequential_read_main):
//   CLK      clock
//   RST      synchronous active-high reset
//   BUSY     high from count latch until the last report word is enqueued
//   DONE     one-cycle pulse as the third report word is enqueued
//   SUM      running 32-bit sum of every lane of every word read
//   ERR_CNT  saturating count of lanes that differ from the fill pattern
//
// Optional feature macro: SEQUENTIAL_READ_CHECK_EN
//   defined   -> each lane is compared against word_index*SIMD_WIDTH + lane
//   undefined -> no comparator is built and ERR_CNT stays 0 (report is still 3 words)
//
// Also in this file: the CoRAM memory/channel models and the FIFO the channel uses.

// Generic FIFO with a registered read port: q holds the popped word the cycle after deq.
// Latency: 1 cycle from deq to q.
// Backpressure: full asserts one entry early so a producer with a registered enq cannot overflow.
module sequential_read_fifo #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         enq,
  input  logic [W-1:0] d,
  input  logic         deq,
  output logic [W-1:0] q,
  output logic         empty,
  output logic         full
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_enq;
  logic          do_deq;

  assign do_enq = enq && (cnt != (AW+1)'(DEPTH));
  assign do_deq = deq && (cnt != '0);
  assign empty  = (cnt == '0);
  // One slot of headroom: the producer's enq is registered, so it acts on a
  // full flag that is one cycle old.
  assign full   = (cnt >= (AW+1)'(DEPTH - 1));

  always_ff @(posedge CLK) begin
    if (do_enq) mem[wr_ptr] <= d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      q      <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + AW'(1);
      if (do_deq) begin
        q      <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// CoRAM single-port scratchpad model (control thread fills it through the array).
// Latency: Q is valid 1 cycle after ADDR.
// Backpressure: none.
module CoramMemory1P #(
  parameter int CORAM_ADDR_LEN   = 12,
  parameter int CORAM_DATA_WIDTH = 128
) (
  input  logic                        CLK,
  input  logic [CORAM_ADDR_LEN-1:0]   ADDR,
  input  logic [CORAM_DATA_WIDTH-1:0] D,
  input  logic                        WE,
  output logic [CORAM_DATA_WIDTH-1:0] Q
);
  logic [CORAM_DATA_WIDTH-1:0] mem [1 << CORAM_ADDR_LEN];

  always_ff @(posedge CLK) begin
    if (WE) mem[ADDR] <= D;
    Q <= mem[ADDR];
  end
endmodule

// CoRAM channel model: thread->user and user->thread FIFOs.
// Latency: Q is valid 1 cycle after DEQ.
// Backpressure: FULL rises on user->thread FIFO headroom or when the thread holds off (th_hold).
module CoramChannel #(
  parameter int CORAM_ADDR_LEN   = 4,
  parameter int CORAM_DATA_WIDTH = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [CORAM_DATA_WIDTH-1:0] D,
  input  logic                        ENQ,
  output logic                        FULL,
  output logic [CORAM_DATA_WIDTH-1:0] Q,
  input  logic                        DEQ,
  output logic                        EMPTY
);
  // Control-thread side. The thread drives these from outside the RTL; reset
  // puts them back to idle.
  logic                        th_enq;
  logic                        th_deq;
  logic                        th_hold;
  logic [CORAM_DATA_WIDTH-1:0] th_d;
  logic [CORAM_DATA_WIDTH-1:0] th_q;
  logic                        th_empty;
  logic                        th_full;
  logic                        u2t_full;

  always_ff @(posedge CLK) begin
    if (RST) begin
      th_enq  <= 1'b0;
      th_deq  <= 1'b0;
      th_hold <= 1'b0;
      th_d    <= '0;
    end
  end

  sequential_read_fifo #(.W(CORAM_DATA_WIDTH), .AW(CORAM_ADDR_LEN)) u_t2u (
    .CLK(CLK), .RST(RST), .enq(th_enq && !th_full), .d(th_d), .deq(DEQ),
    .q(Q), .empty(EMPTY), .full(th_full)
  );

  sequential_read_fifo #(.W(CORAM_DATA_WIDTH), .AW(CORAM_ADDR_LEN)) u_u2t (
    .CLK(CLK), .RST(RST), .enq(ENQ), .d(D), .deq(th_deq && !th_empty),
    .q(th_q), .empty(th_empty), .full(u2t_full)
  );

  assign FULL = u2t_full || th_hold;
endmodule

// Sequential-read benchmark core.
// Latency: N reads + 1 drain cycle, then 3 report words (count, sum, errors).
// Backpressure: REP0..REP2 hold on comm_full with comm_d and counters stable.
module sequential_read_main #(
  parameter int SIMD_WIDTH     = 4,
  parameter int LOG_SIMD_WIDTH = 2,
  parameter int W_D            = 32,
  parameter int W_A            = 12,
  parameter int W_COMM_D       = 32,
  parameter int W_COMM_A       = 4
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] SUM,
  output logic [31:0] ERR_CNT
);
  localparam int W_MEM     = W_D << LOG_SIMD_WIDTH;
  localparam int MEM_WORDS = 1 << W_A;

  // POP waits for the channel's registered read port after comm_deq.
  typedef enum logic [2:0] {IDLE, POP, LATCH, READ, DRAIN, REP0, REP1, REP2} state_t;
  state_t state;

  logic [W_A-1:0]      mem_addr;
  logic [W_MEM-1:0]    mem_q;
  logic                comm_enq;
  logic                comm_deq;
  logic                comm_full;
  logic                comm_empty;
  logic [W_COMM_D-1:0] comm_d;
  logic [W_COMM_D-1:0] comm_q;
  logic [31:0]         cyclecount;
  logic [W_A:0]        n_words;   // one bit wider than the address so 2^W_A fits
  logic [W_A:0]        issued;
  logic                rd_valid;  // mem_q holds a requested word this cycle
  logic [31:0]         lane_sum;

  CoramMemory1P #(.CORAM_ADDR_LEN(W_A), .CORAM_DATA_WIDTH(W_MEM)) u_mem (
    .CLK(CLK), .ADDR(mem_addr), .D('0), .WE(1'b0), .Q(mem_q)
  );

  CoramChannel #(.CORAM_ADDR_LEN(W_COMM_A), .CORAM_DATA_WIDTH(W_COMM_D)) u_comm (
    .CLK(CLK), .RST(RST), .D(comm_d), .ENQ(comm_enq), .FULL(comm_full),
    .Q(comm_q), .DEQ(comm_deq), .EMPTY(comm_empty)
  );

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < SIMD_WIDTH; l++) begin
      lane_sum = lane_sum + 32'(mem_q[l*W_D +: W_D]);
    end
  end

`ifdef SEQUENTIAL_READ_CHECK_EN
  logic [W_A-1:0]          rd_addr;   // address of the word now in mem_q
  logic [LOG_SIMD_WIDTH:0] lane_errs;
  logic [32:0]             err_sum;

  // Expected lane value is {word_index, lane}, truncated to the lane width.
  always_comb begin
    lane_errs = '0;
    for (int l = 0; l < SIMD_WIDTH; l++) begin
      if (mem_q[l*W_D +: W_D] != W_D'({rd_addr, LOG_SIMD_WIDTH'(l)})) begin
        lane_errs = lane_errs + (LOG_SIMD_WIDTH+1)'(1);
      end
    end
    err_sum = {1'b0, ERR_CNT} + 33'(lane_errs);
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      SUM        <= '0;
      ERR_CNT    <= '0;
      comm_enq   <= 1'b0;
      comm_deq   <= 1'b0;
      comm_d     <= '0;
      mem_addr   <= '0;
      cyclecount <= '0;
      n_words    <= '0;
      issued     <= '0;
      rd_valid   <= 1'b0;
`ifdef SEQUENTIAL_READ_CHECK_EN
      rd_addr    <= '0;
`endif
    end else begin
      comm_enq <= 1'b0;
      comm_deq <= 1'b0;
      DONE     <= 1'b0;
      rd_valid <= 1'b0;

      // The last word arrives during DRAIN, so SUM is final when REP0 reads it.
      if (rd_valid) begin
        SUM <= SUM + lane_sum;
`ifdef SEQUENTIAL_READ_CHECK_EN
        ERR_CNT <= err_sum[32] ? '1 : err_sum[31:0];
`endif
      end

      if (state == READ || state == DRAIN) cyclecount <= cyclecount + 32'd1;

      case (state)
        IDLE: begin
          if (!comm_empty) begin
            comm_deq <= 1'b1;
            state    <= POP;
          end
        end
        POP: begin
          // BUSY is raised here so it is already high in the LATCH cycle.
          BUSY  <= 1'b1;
          state <= LATCH;
        end
        LATCH: begin
          if (comm_q > W_COMM_D'(MEM_WORDS)) n_words <= (W_A+1)'(MEM_WORDS);
          else                               n_words <= comm_q[W_A:0];
          SUM        <= '0;
          ERR_CNT    <= '0;
          cyclecount <= '0;
          mem_addr   <= '0;
          issued     <= '0;
          state      <= (comm_q == '0) ? REP0 : READ;
        end
        READ: begin
          rd_valid <= 1'b1;
`ifdef SEQUENTIAL_READ_CHECK_EN
          rd_addr  <= mem_addr;
`endif
          mem_addr <= mem_addr + W_A'(1);
          issued   <= issued + (W_A+1)'(1);
          if (issued == n_words - (W_A+1)'(1)) state <= DRAIN;
        end
        DRAIN: state <= REP0;
        REP0: begin
          if (!comm_full) begin
            comm_enq <= 1'b1;
            comm_d   <= W_COMM_D'(cyclecount);
            state    <= REP1;
          end
        end
        REP1: begin
          if (!comm_full) begin
            comm_enq <= 1'b1;
            comm_d   <= W_COMM_D'(SUM);
            state    <= REP2;
          end
        end
        REP2: begin
          if (!comm_full) begin
            comm_enq <= 1'b1;
            comm_d   <= W_COMM_D'(ERR_CNT);
            DONE     <= 1'b1;
            BUSY     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sequential_read_main.sv
// Directed bench for sequential_read_main: acts as the control thread through
// the CoRAM model's thread-side signals and memory array.
module tb_sequential_read_main;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        BUSY;
  logic        DONE;
  logic [31:0] SUM;
  logic [31:0] ERR_CNT;
  int total = 0;
  int bad   = 0;

`ifdef SEQUENTIAL_READ_CHECK_EN
  localparam logic [31:0] CORRUPT_ERRS = 32'd1;
`else
  localparam logic [31:0] CORRUPT_ERRS = 32'd0;
`endif

  always #5 CLK = ~CLK;

  sequential_read_main dut (
    .CLK(CLK), .RST(RST), .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .ERR_CNT(ERR_CNT)
  );

  function automatic logic [127:0] pattern(input int i);
    logic [127:0] w;
    for (int l = 0; l < 4; l++) w[l*32 +: 32] = 32'(i * 4 + l);
    return w;
  endfunction

  task automatic load_pattern();
    for (int i = 0; i < 4096; i++) dut.u_mem.mem[i] <= pattern(i);
  endtask

  task automatic send_count(input logic [31:0] n);
    @(negedge CLK);
    dut.u_comm.th_d   <= n;
    dut.u_comm.th_enq <= 1'b1;
    @(negedge CLK);
    dut.u_comm.th_enq <= 1'b0;
  endtask

  task automatic read_word(output logic [31:0] w, output bit ok);
    ok = 1'b0;
    w  = '0;
    for (int t = 0; t < 50; t++) begin
      if (!dut.u_comm.th_empty) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (ok) begin
      dut.u_comm.th_deq <= 1'b1;
      @(negedge CLK);
      dut.u_comm.th_deq <= 1'b0;
      w = dut.u_comm.th_q;
    end
  endtask

  // Send a count, watch BUSY/DONE/reads until 3 cycles past DONE, then pull the report.
  task automatic run(input logic [31:0] n, output logic [31:0] r0, output logic [31:0] r1,
                     output logic [31:0] r2, output int busy_cyc, output int done_cnt,
                     output int rd_cnt, output bit ok);
    int  post;
    bit  k0, k1, k2;
    busy_cyc = 0; done_cnt = 0; rd_cnt = 0; post = -1;
    send_count(n);
    for (int t = 0; t < 6000 && post < 3; t++) begin
      @(negedge CLK);
      if (BUSY) busy_cyc++;
      if (dut.rd_valid) rd_cnt++;
      if (DONE) begin
        done_cnt++;
        if (post < 0) post = 0;
      end
      if (post >= 0) post++;
    end
    read_word(r0, k0);
    read_word(r1, k1);
    read_word(r2, k2);
    ok = (post >= 0) && k0 && k1 && k2;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b required 0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b required 0", DONE); end
    total++; if (SUM !== 32'd0) begin bad++; $display("FAIL reset_sum: got %0d required 0", SUM); end
    total++; if (ERR_CNT !== 32'd0) begin bad++; $display("FAIL reset_err: got %0d required 0", ERR_CNT); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    logic [31:0] r0, r1, r2; int bc, dc, rc; bit ok;
    run(32'd16, r0, r1, r2, bc, dc, rc, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_complete: got timeout required DONE and 3 words"); end
    total++; if (r0 !== 32'd17) begin bad++; $display("FAIL basic_cycles: got %0d required 17", r0); end
    total++; if (r1 !== 32'd2016) begin bad++; $display("FAIL basic_sum: got %0d required 2016", r1); end
    total++; if (r2 !== 32'd0) begin bad++; $display("FAIL basic_err: got %0d required 0", r2); end
    total++; if (dc != 1) begin bad++; $display("FAIL basic_done_pulses: got %0d required 1", dc); end
    total++; if (bc != 21) begin bad++; $display("FAIL basic_busy_cycles: got %0d required 21", bc); end
    total++; if (rc != 16) begin bad++; $display("FAIL basic_reads: got %0d required 16", rc); end
    total++; if (SUM !== 32'd2016) begin bad++; $display("FAIL basic_sum_port: got %0d required 2016", SUM); end
  endtask

  task automatic test_zero();
    logic [31:0] r0, r1, r2; int bc, dc, rc; bit ok;
    run(32'd0, r0, r1, r2, bc, dc, rc, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_complete: got timeout required DONE and 3 words"); end
    total++; if ({r0, r1, r2} !== 96'd0) begin bad++; $display("FAIL zero_report: got %0d/%0d/%0d required 0/0/0", r0, r1, r2); end
    total++; if (bc != 4) begin bad++; $display("FAIL zero_busy_cycles: got %0d required 4", bc); end
    total++; if (rc != 0) begin bad++; $display("FAIL zero_reads: got %0d required 0", rc); end
    total++; if (dc != 1) begin bad++; $display("FAIL zero_done_pulses: got %0d required 1", dc); end
  endtask

  task automatic test_corrupt();
    logic [31:0] r0, r1, r2; int bc, dc, rc; bit ok; logic [127:0] w;
    w = pattern(5);
    w[95:64] = 32'h0000DEAD;
    dut.u_mem.mem[5] <= w;
    run(32'd8, r0, r1, r2, bc, dc, rc, ok);
    total++; if (!ok) begin bad++; $display("FAIL corrupt_complete: got timeout required DONE and 3 words"); end
    total++; if (r0 !== 32'd9) begin bad++; $display("FAIL corrupt_cycles: got %0d required 9", r0); end
    total++; if (r1 !== 32'd57479) begin bad++; $display("FAIL corrupt_sum: got %0d required 57479", r1); end
    total++; if (r2 !== CORRUPT_ERRS) begin bad++; $display("FAIL corrupt_err: got %0d required %0d", r2, CORRUPT_ERRS); end
    total++; if (ERR_CNT !== CORRUPT_ERRS) begin bad++; $display("FAIL corrupt_err_port: got %0d required %0d", ERR_CNT, CORRUPT_ERRS); end
    dut.u_mem.mem[5] <= pattern(5);
  endtask

  task automatic test_clamp();
    logic [31:0] r0, r1, r2; int bc, dc, rc; bit ok;
    run(32'd5000, r0, r1, r2, bc, dc, rc, ok);
    total++; if (!ok) begin bad++; $display("FAIL clamp_complete: got timeout required DONE and 3 words"); end
    total++; if (r0 !== 32'd4097) begin bad++; $display("FAIL clamp_cycles: got %0d required 4097", r0); end
    total++; if (r1 !== 32'd134209536) begin bad++; $display("FAIL clamp_sum: got %0d required 134209536", r1); end
    total++; if (r2 !== 32'd0) begin bad++; $display("FAIL clamp_err: got %0d required 0", r2); end
    total++; if (rc != 4096) begin bad++; $display("FAIL clamp_reads: got %0d required 4096", rc); end
    total++; if (bc != 4101) begin bad++; $display("FAIL clamp_busy_cycles: got %0d required 4101", bc); end
  endtask

  task automatic test_stall();
    logic [31:0] r0, r1, r2; bit found, k0, k1, k2; int enq_hold, enq_after, sum_moves;
    found = 1'b0; enq_hold = 0; enq_after = 0; sum_moves = 0;
    send_count(32'd2);
    for (int t = 0; t < 100; t++) begin
      @(negedge CLK);
      if (dut.comm_enq) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (!found) begin bad++; $display("FAIL stall_first_word: got no enqueue required one within 100 cycles"); end
    dut.u_comm.th_hold <= 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge CLK);
      if (dut.comm_enq) enq_hold++;
      if (SUM !== 32'd28) sum_moves++;
    end
    total++; if (enq_hold != 0) begin bad++; $display("FAIL stall_enq_while_full: got %0d required 0", enq_hold); end
    total++; if (sum_moves != 0) begin bad++; $display("FAIL stall_sum_stable: got %0d unstable cycles required 0", sum_moves); end
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL stall_busy: got %0b required 1", BUSY); end
    dut.u_comm.th_hold <= 1'b0;
    found = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge CLK);
      if (dut.comm_enq) enq_after++;
      if (DONE) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (!found) begin bad++; $display("FAIL stall_done: got no DONE required DONE after release"); end
    total++; if (enq_after != 2) begin bad++; $display("FAIL stall_enq_after: got %0d required 2", enq_after); end
    @(negedge CLK);
    read_word(r0, k0);
    read_word(r1, k1);
    read_word(r2, k2);
    total++; if (!(k0 && k1 && k2)) begin bad++; $display("FAIL stall_words: got missing word required 3 words"); end
    total++; if ({r0, r1, r2} !== {32'd3, 32'd28, 32'd0}) begin bad++; $display("FAIL stall_report: got %0d/%0d/%0d required 3/28/0", r0, r1, r2); end
    total++; if (dut.u_comm.th_empty !== 1'b1) begin bad++; $display("FAIL stall_extra_words: got non-empty channel required empty"); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] r0, r1, r2; int bc, dc, rc, extra; bit ok;
    extra = 0;
    send_count(32'd100);
    repeat (30) @(negedge CLK);
    total++; if (BUSY !== 1'b1 || SUM === 32'd0) begin bad++; $display("FAIL midread_progress: got busy=%0b sum=%0d required busy=1 sum>0", BUSY, SUM); end
    RST = 1'b1;
    @(negedge CLK);
    total++; if ({BUSY, DONE} !== 2'b00) begin bad++; $display("FAIL midread_rst_flags: got busy=%0b done=%0b required 0/0", BUSY, DONE); end
    total++; if (SUM !== 32'd0 || ERR_CNT !== 32'd0) begin bad++; $display("FAIL midread_rst_counts: got sum=%0d err=%0d required 0/0", SUM, ERR_CNT); end
    RST = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK);
      if (DONE || dut.comm_enq) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL midread_no_report: got %0d pulses required 0", extra); end
    total++; if (dut.u_comm.th_empty !== 1'b1) begin bad++; $display("FAIL midread_channel_empty: got non-empty required empty"); end
    run(32'd4, r0, r1, r2, bc, dc, rc, ok);
    total++; if (!ok) begin bad++; $display("FAIL after_rst_complete: got timeout required DONE and 3 words"); end
    total++; if ({r0, r1, r2} !== {32'd5, 32'd120, 32'd0}) begin bad++; $display("FAIL after_rst_report: got %0d/%0d/%0d required 5/120/0", r0, r1, r2); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running required finish before 900000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    load_pattern();
    test_basic();
    test_zero();
    test_corrupt();
    test_clamp();
    test_stall();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
